trs_bus_sync: RTL and testbench
===============================

// Module: trs_bus_sync
// PURPOSE
//  Front end between the raw TRS-80 expansion bus and the internal 100 MHz fabric.
//  - Synchronises and de-glitches the active-low strobes WR_N, RD_N, OUT_N and IN_N.
//  - Emits one-clock falling-edge pulses and frozen TRS_A/TRS_D buses for the display, LE18 and port peripherals.
//  - Owns the IN read-response path: waits for peripheral data, then drives the bus data byte until IN_N releases.
// PARAMETERS
//  SYNC_STAGES   2   flops in each input synchroniser (2..4)
//  FILTER_LEN    3   consecutive equal synced samples needed before a strobe changes state (1..15)
//  TIMEOUT_CYC   16  clocks to wait for rd_data_rdy before answering 8'hFF
// PORTS
//  clk               in   1   100 MHz system clock
//  rst_n             in   1   asynchronous, active-low reset
//  TRS_A_raw         in   16  raw bus address
//  TRS_D_raw         in   8   raw bus data
//  TRS_WR_N/RD_N/OUT_N/IN_N  in 1 each  raw active-low strobes
//  TRS_A             out  16  synced address, frozen while any strobe active
//  TRS_D             out  8   synced data, frozen likewise
//  WR/RD/OUT/IN_falling_edge  out 1 each  one-clk pulse on filtered strobe assertion
//  rd_claim          in   1   peripheral decodes current IN port; sampled with IN_falling_edge
//  rd_data           in   8   peripheral read data
//  rd_data_rdy       in   1   rd_data valid this clk
//  TRS_D_out         out  8   data to drive onto the bus
//  TRS_D_oe          out  1   bus driver enable
// BEHAVIOUR
//  Reset: all pulses 0, TRS_A=0, TRS_D=0, TRS_D_out=0, TRS_D_oe=0, FSM=IDLE, filtered strobes=1 (inactive). All asynchronous.
//  Strobe path: SYNC_STAGES flops, then a filter counter, then a prev-register edge detect.
//  - Filtered state flips after FILTER_LEN consecutive synced samples differ from it; any equal sample clears the counter.
//  - Latency: pulse is high exactly 1 clk, SYNC_STAGES+FILTER_LEN+1 clks after the first clk edge that samples raw low (6 at defaults).
//  - Rising edges produce no pulse.
//  A/D path: SYNC_STAGES+FILTER_LEN delay stages, so bus data aligns with the filtered strobes.
//  - Output register loads every clk while all filtered strobes are high.
//  - It loads in the pulse clk, then holds until all filtered strobes are high again.
//  - Simultaneous strobes (illegal on the bus): every edge is reported independently; the freeze lasts until the last one releases.
//  Read FSM:
//  - IDLE: on IN_falling_edge with rd_claim=1 -> WAIT; unclaimed -> stay in IDLE with oe=0.
//  - WAIT: 4-bit counter increments. On rd_data_rdy, TRS_D_out<=rd_data -> DRIVE.
//    When the counter reaches TIMEOUT_CYC-1 without rdy, TRS_D_out<=8'hFF -> DRIVE.
//    If filtered IN_N rises in WAIT -> IDLE with no drive.
//  - DRIVE: TRS_D_oe=1 (registered, first high the clk after the transition). On filtered IN_N high -> IDLE, oe=0 in the same clk.
//  - rdy in the same clk as timeout: rd_data wins. rd_data_rdy outside WAIT is ignored.
//  - IN_falling_edge while not IDLE cannot occur; it is ignored.
//  - rst_n low mid-operation: oe drops immediately (async); no pending pulse survives.
// CONFIGURATION
//  TRS_GLITCH_FILTER_EN defined: filter as above.
//  Not defined: the filter is a wire (filtered = synced); A/D delay shrinks to SYNC_STAGES; pulse latency is SYNC_STAGES+1.
//  FILTER_LEN is ignored when the filter is compiled out.
// STRUCTURE
//  Package trs_bus_pkg:
//  - strobe index constants STB_WR=0, STB_RD=1, STB_OUT=2, STB_IN=3;
//  - read FSM state typedef {IDLE, WAIT, DRIVE};
//  - TRS_FLOAT_BYTE=8'hFF.
//  Sub-module trs_strobe_filter: synchroniser + filter + edge detect for one strobe; outputs filtered level and fall pulse; instantiated x4.
//  The top level holds the A/D delay line, freeze logic and read FSM.
// TESTING
//  1 WR_N low 300 ns, A=16'h3C05, D=8'h41 -> WR_falling_edge one pulse at clk 6; TRS_A=3C05, TRS_D=41 held until WR_N filtered high.
//  2 OUT_N low 20 ns (2 clks) -> no OUT pulse with TRS_GLITCH_FILTER_EN; one pulse at clk 3 without it.
//  3 IN_N low, A=16'h00EC, rd_claim=1, rd_data_rdy 3 clks after pulse with 8'h5A -> TRS_D_out=5A, oe=1 next clk until IN_N filtered high, then oe=0.
//  4 IN claimed, no rdy -> oe=1 with TRS_D_out=FF 17 clks after pulse.
//  5 IN unclaimed (rd_claim=0) -> oe stays 0 for the whole cycle.
//  6 rst_n low 2 clks while in DRIVE -> oe=0 and TRS_A=0 immediately; after release, no pulse until a fresh strobe assertion.

Source files
------------

// File: rtl/trs_bus_pkg.sv
// Shared constants and types for the TRS-80 bus front end.
// Honours TRS_GLITCH_FILTER_EN (strobe glitch filter compiled in when defined).
package trs_bus_pkg;

    localparam int STB_WR  = 0;
    localparam int STB_RD  = 1;
    localparam int STB_OUT = 2;
    localparam int STB_IN  = 3;
    localparam int NUM_STB = 4;

    localparam logic [7:0] TRS_FLOAT_BYTE = 8'hFF;

`ifdef TRS_GLITCH_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2
    } rd_state_t;

    // Address/data must be delayed by exactly the strobe path's pre-edge-detect latency.
    function automatic int ad_delay(input int sync_stages, input int filter_len);
        return sync_stages + (FILTER_ON ? filter_len : 0);
    endfunction

endpackage

// File: rtl/trs_strobe_filter.sv
// One strobe lane: synchroniser, optional glitch filter (TRS_GLITCH_FILTER_EN), falling-edge pulse.
module trs_strobe_filter
    import trs_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef TRS_GLITCH_FILTER_EN
    ,
    parameter int FILTER_LEN  = 3
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_n_raw,
    output logic level,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   level_d;

    // NOTE: every clocked register uses non-blocking assignment so all flops
    // sample pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_n_raw};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef TRS_GLITCH_FILTER_EN
    logic [3:0] cnt_q;
    logic       filt_q;

    // Any sample that agrees with the current level restarts the run count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else if (synced == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == 4'(FILTER_LEN - 1)) begin
            cnt_q  <= '0;
            filt_q <= synced;
        end else begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign level = filt_q;
`else
    assign level = synced;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b1;
            fall    <= 1'b0;
        end else begin
            level_d <= level;
            fall    <= level_d & ~level;
        end
    end

endmodule

// File: rtl/trs_bus_sync.sv
// TRS-80 expansion bus front end: strobe sync/filter, frozen A/D, IN read-response FSM.
// Honours TRS_GLITCH_FILTER_EN (see trs_strobe_filter).
module trs_bus_sync
    import trs_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] TRS_A_raw,
    input  logic [7:0]  TRS_D_raw,
    input  logic        TRS_WR_N,
    input  logic        TRS_RD_N,
    input  logic        TRS_OUT_N,
    input  logic        TRS_IN_N,
    output logic [15:0] TRS_A,
    output logic [7:0]  TRS_D,
    output logic        WR_falling_edge,
    output logic        RD_falling_edge,
    output logic        OUT_falling_edge,
    output logic        IN_falling_edge,
    input  logic        rd_claim,
    input  logic [7:0]  rd_data,
    input  logic        rd_data_rdy,
    output logic [7:0]  TRS_D_out,
    output logic        TRS_D_oe
);

    localparam int AD_DELAY = ad_delay(SYNC_STAGES, FILTER_LEN);
    localparam int CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [NUM_STB-1:0] strobe_n_raw;
    logic [NUM_STB-1:0] levels;
    logic [NUM_STB-1:0] falls;

    assign strobe_n_raw[STB_WR]  = TRS_WR_N;
    assign strobe_n_raw[STB_RD]  = TRS_RD_N;
    assign strobe_n_raw[STB_OUT] = TRS_OUT_N;
    assign strobe_n_raw[STB_IN]  = TRS_IN_N;

    for (genvar g = 0; g < NUM_STB; g++) begin : g_strobe
        trs_strobe_filter #(
            .SYNC_STAGES (SYNC_STAGES)
`ifdef TRS_GLITCH_FILTER_EN
            ,
            .FILTER_LEN  (FILTER_LEN)
`endif
        ) u_filter (
            .clk          (clk),
            .rst_n        (rst_n),
            .strobe_n_raw (strobe_n_raw[g]),
            .level        (levels[g]),
            .fall         (falls[g])
        );
    end

    assign WR_falling_edge  = falls[STB_WR];
    assign RD_falling_edge  = falls[STB_RD];
    assign OUT_falling_edge = falls[STB_OUT];
    assign IN_falling_edge  = falls[STB_IN];

    // ------------------------------------------------------------------
    // Address/data delay line and freeze register
    // ------------------------------------------------------------------
    logic [AD_DELAY-1:0][23:0] ad_pipe;
    logic                      all_high_q;

    // NOTE: the delay line is a plain shift register, so it is reset along with
    // everything else; a stale pipe would otherwise leak into TRS_A after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ad_pipe    <= '0;
            all_high_q <= 1'b1;
            TRS_A      <= '0;
            TRS_D      <= '0;
        end else begin
            ad_pipe    <= {ad_pipe[AD_DELAY-2:0], {TRS_A_raw, TRS_D_raw}};
            all_high_q <= &levels;
            // One-clock-late view of the levels lets the load land in the pulse clock.
            if (all_high_q) begin
                {TRS_A, TRS_D} <= ad_pipe[AD_DELAY-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // IN read-response FSM
    // ------------------------------------------------------------------
    rd_state_t        state_q;
    logic [CNT_W-1:0] wait_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            TRS_D_out  <= '0;
            TRS_D_oe   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    TRS_D_oe <= 1'b0;
                    if (IN_falling_edge && rd_claim) begin
                        state_q    <= WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                WAIT: begin
                    if (levels[STB_IN]) begin
                        state_q <= IDLE;
                    end else if (rd_data_rdy) begin
                        TRS_D_out <= rd_data;
                        TRS_D_oe  <= 1'b1;
                        state_q   <= DRIVE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        TRS_D_out <= TRS_FLOAT_BYTE;
                        TRS_D_oe  <= 1'b1;
                        state_q   <= DRIVE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                DRIVE: begin
                    if (levels[STB_IN]) begin
                        TRS_D_oe <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    TRS_D_oe <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trs_bus_sync.sv
// Scoreboard bench for trs_bus_sync: stimulus queues expected events, a monitor matches them.
module tb_trs_bus_sync;
    import trs_bus_pkg::*;

`ifdef TRS_GLITCH_FILTER_EN
    localparam int LAT  = 6;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = 3;
    localparam bit FILT = 1'b0;
`endif

    localparam int EV_WR  = 0;
    localparam int EV_OUT = 2;
    localparam int EV_IN  = 3;
    localparam int EV_OE  = 4;

    typedef struct {
        int          kind;
        int          cyc;
        logic [15:0] a;
        logic [7:0]  d;
    } exp_t;

    exp_t exp_q[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] TRS_A_raw;
    logic [7:0]  TRS_D_raw;
    logic        TRS_WR_N, TRS_RD_N, TRS_OUT_N, TRS_IN_N;
    logic [15:0] TRS_A;
    logic [7:0]  TRS_D;
    logic        WR_falling_edge, RD_falling_edge, OUT_falling_edge, IN_falling_edge;
    logic        rd_claim;
    logic [7:0]  rd_data;
    logic        rd_data_rdy;
    logic [7:0]  TRS_D_out;
    logic        TRS_D_oe;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    trs_bus_sync dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .TRS_A_raw        (TRS_A_raw),
        .TRS_D_raw        (TRS_D_raw),
        .TRS_WR_N         (TRS_WR_N),
        .TRS_RD_N         (TRS_RD_N),
        .TRS_OUT_N        (TRS_OUT_N),
        .TRS_IN_N         (TRS_IN_N),
        .TRS_A            (TRS_A),
        .TRS_D            (TRS_D),
        .WR_falling_edge  (WR_falling_edge),
        .RD_falling_edge  (RD_falling_edge),
        .OUT_falling_edge (OUT_falling_edge),
        .IN_falling_edge  (IN_falling_edge),
        .rd_claim         (rd_claim),
        .rd_data          (rd_data),
        .rd_data_rdy      (rd_data_rdy),
        .TRS_D_out        (TRS_D_out),
        .TRS_D_oe         (TRS_D_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every pulse or oe rise must match the head of the scoreboard.
    logic [4:0] ev;
    logic       oe_prev = 1'b0;
    exp_t       e;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                ev = {TRS_D_oe & ~oe_prev, IN_falling_edge, OUT_falling_edge,
                      RD_falling_edge, WR_falling_edge};
                for (int k = 0; k < 5; k++) begin
                    if (ev[k]) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", k, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            check("event_kind", k, e.kind);
                            check("event_cycle", cyc, e.cyc);
                            if (k == EV_OE) begin
                                check("oe_data", {24'd0, TRS_D_out}, {24'd0, e.d});
                            end else begin
                                check("pulse_addr", {16'd0, TRS_A}, {16'd0, e.a});
                                check("pulse_data", {24'd0, TRS_D}, {24'd0, e.d});
                            end
                        end
                    end
                end
            end
            oe_prev = TRS_D_oe;
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, p, m;
        rst_n = 1'b0;
        TRS_A_raw = '0; TRS_D_raw = '0;
        TRS_WR_N = 1'b1; TRS_RD_N = 1'b1; TRS_OUT_N = 1'b1; TRS_IN_N = 1'b1;
        rd_claim = 1'b0; rd_data = '0; rd_data_rdy = 1'b0;

        #23;
        check("rst_trs_a", {16'd0, TRS_A}, 32'd0);
        check("rst_trs_d", {24'd0, TRS_D}, 32'd0);
        check("rst_d_out", {24'd0, TRS_D_out}, 32'd0);
        check("rst_oe", {31'd0, TRS_D_oe}, 32'd0);
        check("rst_pulses", {28'd0, IN_falling_edge, OUT_falling_edge, RD_falling_edge, WR_falling_edge}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: WR cycle, bus changes mid-strobe but outputs stay frozen
        n = cyc;
        TRS_A_raw = 16'h3C05; TRS_D_raw = 8'h41; TRS_WR_N = 1'b0;
        exp_q.push_back('{EV_WR, n + LAT, 16'h3C05, 8'h41});
        wait_until(n + 12);
        TRS_A_raw = 16'hFFFF; TRS_D_raw = 8'h00;
        wait_until(n + 25);
        check("t1_hold_a", {16'd0, TRS_A}, 32'h3C05);
        check("t1_hold_d", {24'd0, TRS_D}, 32'h41);
        wait_until(n + 30);
        TRS_WR_N = 1'b1;
        wait_until(n + 50);
        check("t1_release_a", {16'd0, TRS_A}, 32'hFFFF);
        check("t1_release_d", {24'd0, TRS_D}, 32'h00);

        // 2: 2-clock OUT glitch
        n = cyc;
        TRS_A_raw = 16'h00F0; TRS_D_raw = 8'h05; TRS_OUT_N = 1'b0;
        if (!FILT) exp_q.push_back('{EV_OUT, n + 3, 16'h00F0, 8'h05});
        repeat (2) @(negedge clk);
        TRS_OUT_N = 1'b1;
        wait_until(n + 20);

        // 3: claimed IN, data ready 3 clocks after the pulse
        n = cyc;
        TRS_A_raw = 16'h00EC; TRS_D_raw = 8'h12; rd_claim = 1'b1; TRS_IN_N = 1'b0;
        p = n + LAT;
        exp_q.push_back('{EV_IN, p, 16'h00EC, 8'h12});
        wait_until(p + 2);
        rd_data = 8'h5A; rd_data_rdy = 1'b1;
        exp_q.push_back('{EV_OE, p + 3, 16'h0, 8'h5A});
        wait_until(p + 3);
        rd_data_rdy = 1'b0; rd_data = 8'h00;
        wait_until(p + 10);
        check("t3_oe_on", {31'd0, TRS_D_oe}, 32'd1);
        check("t3_d_out", {24'd0, TRS_D_out}, 32'h5A);
        TRS_IN_N = 1'b1;
        m = cyc;
        wait_until(m + 2);
        check("t3_oe_held", {31'd0, TRS_D_oe}, 32'd1);
        wait_until(m + LAT + 2);
        check("t3_oe_off", {31'd0, TRS_D_oe}, 32'd0);
        rd_claim = 1'b0;
        wait_until(cyc + 5);

        // 4: claimed IN with no ready -> float byte after the timeout
        n = cyc;
        TRS_A_raw = 16'h00ED; TRS_D_raw = 8'h34; rd_claim = 1'b1; TRS_IN_N = 1'b0;
        p = n + LAT;
        exp_q.push_back('{EV_IN, p, 16'h00ED, 8'h34});
        exp_q.push_back('{EV_OE, p + 17, 16'h0, 8'hFF});
        wait_until(p + 1);
        rd_claim = 1'b0;
        wait_until(p + 16);
        check("t4_oe_before_timeout", {31'd0, TRS_D_oe}, 32'd0);
        wait_until(p + 20);
        check("t4_oe_on", {31'd0, TRS_D_oe}, 32'd1);
        check("t4_d_out", {24'd0, TRS_D_out}, 32'hFF);
        TRS_IN_N = 1'b1;
        wait_until(cyc + LAT + 4);

        // 5: unclaimed IN; a stray ready must be ignored
        n = cyc;
        TRS_A_raw = 16'h00EE; TRS_D_raw = 8'h56; rd_claim = 1'b0; TRS_IN_N = 1'b0;
        p = n + LAT;
        exp_q.push_back('{EV_IN, p, 16'h00EE, 8'h56});
        wait_until(p + 3);
        rd_data = 8'h99; rd_data_rdy = 1'b1;
        @(negedge clk);
        rd_data_rdy = 1'b0;
        wait_until(p + 20);
        check("t5_oe_off", {31'd0, TRS_D_oe}, 32'd0);
        TRS_IN_N = 1'b1;
        wait_until(cyc + LAT + 4);
        check("t5_oe_still_off", {31'd0, TRS_D_oe}, 32'd0);

        // 6: reset while driving
        n = cyc;
        TRS_A_raw = 16'h00EF; TRS_D_raw = 8'h9A; rd_claim = 1'b1; TRS_IN_N = 1'b0;
        p = n + LAT;
        exp_q.push_back('{EV_IN, p, 16'h00EF, 8'h9A});
        wait_until(p + 2);
        rd_data = 8'hC3; rd_data_rdy = 1'b1;
        exp_q.push_back('{EV_OE, p + 3, 16'h0, 8'hC3});
        wait_until(p + 3);
        rd_data_rdy = 1'b0; rd_claim = 1'b0;
        wait_until(p + 8);
        check("t6_oe_before_rst", {31'd0, TRS_D_oe}, 32'd1);
        #2;
        rst_n = 1'b0; TRS_IN_N = 1'b1;
        #1;
        check("t6_rst_oe", {31'd0, TRS_D_oe}, 32'd0);
        check("t6_rst_trs_a", {16'd0, TRS_A}, 32'd0);
        check("t6_rst_d_out", {24'd0, TRS_D_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_until(cyc + 20);
        n = cyc;
        TRS_A_raw = 16'h1234; TRS_D_raw = 8'h77; TRS_WR_N = 1'b0;
        exp_q.push_back('{EV_WR, n + LAT, 16'h1234, 8'h77});
        wait_until(n + 20);
        TRS_WR_N = 1'b1;
        wait_until(n + 40);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
